tlk2711_axil_bridge: RTL and testbench

AXI4-Lite slave that converts PS register accesses into the 64-bit register strobe interface of the TLK2711 core: write enable, write address and write data, plus read enable, read address and read data. It sits directly upstream of the core's register port, between the PS AXI-Lite master and the core's register manager. Each 64-bit register is exposed as two 32-bit words:
- Writes are committed atomically when the high word is written.
- Reads are snapshotted atomically when the low word is read.

---
 rtl/tlk2711_axil_bridge.sv | 146 ++++++++++++++
 tb/tb_tlk2711_axil_bridge.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_axil_bridge.sv
// tlk2711_axil_bridge: AXI4-Lite slave mapping 32-bit word pairs onto the TLK2711 64-bit register strobe port
module tlk2711_axil_bridge #(
  parameter int AXIL_ADDR_WIDTH = 19,
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic s_axil_awvalid,
  output logic s_axil_awready,
  input  logic [31:0] s_axil_wdata,
  input  logic [3:0] s_axil_wstrb,
  input  logic s_axil_wvalid,
  output logic s_axil_wready,
  output logic [1:0] s_axil_bresp,
  output logic s_axil_bvalid,
  input  logic s_axil_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic s_axil_arvalid,
  output logic s_axil_arready,
  output logic [31:0] s_axil_rdata,
  output logic [1:0] s_axil_rresp,
  output logic s_axil_rvalid,
  input  logic s_axil_rready,
  output logic o_reg_wen,
  output logic [15:0] o_reg_waddr,
  output logic [63:0] o_reg_wdata,
  output logic o_reg_ren,
  output logic [15:0] o_reg_raddr,
  input  logic [63:0] i_reg_rdata
);
  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic aw_held, w_held, aw_hi_q;
  logic [15:0] aw_idx_q;
  logic [31:0] w_data_q, stage_lo, shadow_hi;
  logic [3:0] w_strb_q;
  logic [2:0] r_cnt;
  logic aw_hs, w_hs, aw_hi;
  logic [15:0] aw_idx;
  logic [31:0] w_data, w_mask;
  logic [3:0] w_strb;
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};
  assign s_axil_awready = (w_state == W_IDLE) && !aw_held;
  assign s_axil_wready = (w_state == W_IDLE) && !w_held;
  assign s_axil_arready = r_state == R_IDLE;
  assign s_axil_bresp = 2'b00;
  assign s_axil_rresp = 2'b00;
  assign aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_hs = s_axil_wvalid && s_axil_wready;
  // a channel that handshakes in the same cycle as the commit is used directly, otherwise its held copy
  assign aw_idx = aw_held ? aw_idx_q : s_axil_awaddr[18:3];
  assign aw_hi = aw_held ? aw_hi_q : s_axil_awaddr[2];
  assign w_data = w_held ? w_data_q : s_axil_wdata;
  assign w_strb = w_held ? w_strb_q : s_axil_wstrb;
  assign w_mask = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
  // write path: collect AW and W, commit on entry to W_EXEC so wen and bvalid rise together, then respond
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_hi_q <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      stage_lo <= '0;
      s_axil_bvalid <= 1'b0;
      o_reg_wen <= 1'b0;
      o_reg_waddr <= '0;
      o_reg_wdata <= '0;
    end else if (w_state == W_IDLE) begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx_q <= s_axil_awaddr[18:3];
        aw_hi_q <= s_axil_awaddr[2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data_q <= s_axil_wdata;
        w_strb_q <= s_axil_wstrb;
      end
      if ((aw_held || aw_hs) && (w_held || w_hs)) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
        w_state <= W_EXEC;
        s_axil_bvalid <= 1'b1;
        if (aw_hi) begin
          o_reg_wen <= 1'b1;
          o_reg_waddr <= aw_idx;
          o_reg_wdata <= {w_data & w_mask, stage_lo};
        end else begin
          stage_lo <= (stage_lo & ~w_mask) | (w_data & w_mask);
        end
      end
    end else begin
      o_reg_wen <= 1'b0;
      s_axil_bvalid <= !s_axil_bready;
      w_state <= s_axil_bready ? W_IDLE : W_RESP;
    end
  end
  // read path: low half strobes the core and snapshots all 64 bits, high half replays the snapshot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
      r_cnt <= '0;
      shadow_hi <= '0;
      s_axil_rdata <= '0;
      s_axil_rvalid <= 1'b0;
      o_reg_ren <= 1'b0;
      o_reg_raddr <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axil_arvalid && s_axil_araddr[2]) begin
            s_axil_rdata <= shadow_hi;
            s_axil_rvalid <= 1'b1;
            r_state <= R_RESP;
          end else if (s_axil_arvalid) begin
            o_reg_ren <= 1'b1;
            o_reg_raddr <= s_axil_araddr[18:3];
            r_cnt <= 3'(RD_LATENCY);
            r_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          o_reg_ren <= 1'b0;
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd0) begin
            s_axil_rdata <= i_reg_rdata[31:0];
            shadow_hi <= i_reg_rdata[63:32];
            s_axil_rvalid <= 1'b1;
            r_state <= R_RESP;
          end
        end
        default: begin
          s_axil_rvalid <= !s_axil_rready;
          r_state <= s_axil_rready ? R_IDLE : R_RESP;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tlk2711_axil_bridge.sv
// tb_tlk2711_axil_bridge: scoreboard bench for the AXI-Lite to TLK2711 register bridge
module tb_tlk2711_axil_bridge;
  localparam int RDL = 3;
  logic clk = 0, rst = 0;
  logic [18:0] s_axil_awaddr = 0, s_axil_araddr = 0;
  logic s_axil_awvalid = 0, s_axil_wvalid = 0, s_axil_bready = 0, s_axil_arvalid = 0, s_axil_rready = 0;
  logic [31:0] s_axil_wdata = 0;
  logic [3:0] s_axil_wstrb = 0;
  logic s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
  logic [1:0] s_axil_bresp, s_axil_rresp;
  logic [31:0] s_axil_rdata;
  logic o_reg_wen, o_reg_ren;
  logic [15:0] o_reg_waddr, o_reg_raddr;
  logic [63:0] o_reg_wdata, i_reg_rdata;
  tlk2711_axil_bridge #(.AXIL_ADDR_WIDTH(19), .RD_LATENCY(RDL)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .o_reg_wen(o_reg_wen), .o_reg_waddr(o_reg_waddr), .o_reg_wdata(o_reg_wdata),
    .o_reg_ren(o_reg_ren), .o_reg_raddr(o_reg_raddr), .i_reg_rdata(i_reg_rdata)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int errors = 0, checks = 0;
  int wen_cyc = -1, ren_cyc = -1;
  logic [79:0] exp_wen[$];
  logic [15:0] exp_ren[$];
  logic [31:0] exp_rd[$];
  int exp_b = 0;
  logic [63:0] ref_mem[16];
  logic [63:0] emu_mem[16];
  logic [31:0] ref_stage = 0, ref_shadow = 0;
  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] mask(input logic [3:0] s);
    for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{s[i]}};
  endfunction
  // downstream register core: data is valid only in the exact cycle RDL after the read strobe
  int pc = -1;
  logic [15:0] pa = 0;
  always @(negedge clk) begin
    if (o_reg_wen) emu_mem[o_reg_waddr[3:0]] = o_reg_wdata;
    if (o_reg_ren) begin
      pc = RDL;
      pa = o_reg_raddr;
    end else if (pc >= 0) pc--;
    i_reg_rdata = (pc == 0) ? emu_mem[pa[3:0]] : {$urandom, $urandom};
  end
  // monitor: pops the scoreboard whenever the DUT presents a strobe or completes a response
  always @(negedge clk) if (rst) begin
    if (o_reg_wen) begin
      wen_cyc = cyc;
      chk("wen_expected", exp_wen.size() > 0, 1);
      if (exp_wen.size() > 0) chk("wen", {o_reg_waddr, o_reg_wdata}, exp_wen.pop_front());
    end
    if (o_reg_ren) begin
      ren_cyc = cyc;
      chk("ren_expected", exp_ren.size() > 0, 1);
      if (exp_ren.size() > 0) chk("ren_addr", o_reg_raddr, exp_ren.pop_front());
    end
    if (s_axil_rvalid && s_axil_rready) begin
      chk("rresp", s_axil_rresp, 0);
      chk("r_expected", exp_rd.size() > 0, 1);
      if (exp_rd.size() > 0) chk("rdata", s_axil_rdata, exp_rd.pop_front());
    end
    if (s_axil_bvalid && s_axil_bready) begin
      chk("bresp", s_axil_bresp, 0);
      chk("b_expected", exp_b > 0, 1);
      if (exp_b > 0) exp_b--;
    end
  end
  task automatic axi_write(input logic [15:0] idx, input bit hi, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int bdelay, output int last);
    int aw_at, w_at, k, t_aw, t_w;
    bit aw_done, w_done;
    logic [31:0] m;
    m = mask(s);
    if (hi) begin
      exp_wen.push_back({idx, d & m, ref_stage});
      ref_mem[idx[3:0]] = {d & m, ref_stage};
    end else ref_stage = (ref_stage & ~m) | (d & m);
    if (bdelay >= 0) exp_b++;
    aw_at = lead > 0 ? lead : 0;
    w_at = lead < 0 ? -lead : 0;
    aw_done = 0; w_done = 0; k = 0; t_aw = 0; t_w = 0;
    s_axil_awaddr = {idx, hi, 2'b00};
    s_axil_wdata = d;
    s_axil_wstrb = s;
    s_axil_bready = (bdelay == 0);
    while (!(aw_done && w_done) && k < 50) begin
      s_axil_awvalid = !aw_done && k >= aw_at;
      s_axil_wvalid = !w_done && k >= w_at;
      @(negedge clk);
      if (s_axil_awvalid && s_axil_awready) begin aw_done = 1; t_aw = cyc; end
      if (s_axil_wvalid && s_axil_wready) begin w_done = 1; t_w = cyc; end
      @(posedge clk); #1;
      k++;
    end
    s_axil_awvalid = 0;
    s_axil_wvalid = 0;
    chk("w_handshake", {aw_done, w_done}, 2'b11);
    last = t_aw > t_w ? t_aw : t_w;
    @(negedge clk);
    chk("w_latency", {32'(cyc - last), s_axil_bvalid, o_reg_wen}, {32'd1, 1'b1, hi});
    if (bdelay < 0) return;
    for (int i = 0; i < bdelay; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("b_hold", {s_axil_bvalid, s_axil_awready, s_axil_wready, o_reg_wen}, 4'b1000);
    end
    if (bdelay > 0) begin @(posedge clk); #1; s_axil_bready = 1; end
    @(posedge clk); #1;
    s_axil_bready = 0;
    chk("b_done", s_axil_bvalid, 0);
  endtask
  task automatic axi_read(input logic [15:0] idx, input bit hi, input int rdelay, input bit abort);
    int t_ar, t_rv, k;
    logic [31:0] e;
    if (!hi) begin
      exp_ren.push_back(idx);
      e = ref_mem[idx[3:0]][31:0];
      ref_shadow = ref_mem[idx[3:0]][63:32];
    end else e = ref_shadow;
    if (!abort) exp_rd.push_back(e);
    s_axil_araddr = {idx, hi, 2'b00};
    s_axil_arvalid = 1;
    s_axil_rready = (rdelay == 0);
    k = 0; t_ar = -1;
    while (t_ar < 0 && k < 50) begin
      @(negedge clk);
      if (s_axil_arready) t_ar = cyc;
      @(posedge clk); #1;
      k++;
    end
    s_axil_arvalid = 0;
    chk("ar_handshake", t_ar >= 0, 1);
    if (abort) return;
    k = 0; t_rv = -1;
    while (t_rv < 0 && k < 20) begin
      @(negedge clk);
      if (s_axil_rvalid) t_rv = cyc;
      else begin @(posedge clk); #1; end
      k++;
    end
    chk("r_latency", 32'(t_rv - t_ar), hi ? 32'd1 : 32'(2 + RDL));
    if (!hi) chk("ren_cycle", 32'(ren_cyc - t_ar), 32'd1);
    for (int i = 0; i < rdelay; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("r_hold", {s_axil_rvalid, s_axil_arready, s_axil_rdata}, {1'b1, 1'b0, e});
    end
    if (rdelay > 0) begin @(posedge clk); #1; s_axil_rready = 1; end
    @(posedge clk); #1;
    s_axil_rready = 0;
    chk("r_done", s_axil_rvalid, 0);
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("rst_async", {s_axil_bvalid, s_axil_rvalid, o_reg_wen, o_reg_ren, s_axil_awready, s_axil_wready, s_axil_arready}, 7'b0000111);
    ref_stage = 0;
    ref_shadow = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_after", {s_axil_bvalid, s_axil_rvalid, o_reg_wen, o_reg_ren, s_axil_awready, s_axil_wready, s_axil_arready}, 7'b0000111);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  int t1, t2, ta, tb_, ri, rop;
  bit rh;
  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 0;
      emu_mem[i] = 0;
    end
    ref_mem[2] = 64'hDEADBEEF_01234567;
    emu_mem[2] = 64'hDEADBEEF_01234567;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {s_axil_bvalid, s_axil_rvalid, o_reg_wen, o_reg_ren, s_axil_bresp, s_axil_rresp, s_axil_rdata, o_reg_waddr, o_reg_raddr},
        {4'b0000, 4'b0, 32'b0, 32'b0});
    chk("reset_wdata", o_reg_wdata, 0);
    chk("reset_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    axi_write(16'h0008, 0, 32'h1111_2222, 4'hF, 0, 0, t1);
    axi_write(16'h0008, 1, 32'hAAAA_BBBB, 4'hF, 0, 0, t1);
    chk("pair_wdata", ref_mem[8], 64'hAAAABBBB_11112222);
    axi_write(16'h0003, 0, 32'h5555_6666, 4'hF, 3, 5, t1);
    axi_write(16'h0003, 1, 32'h7777_8888, 4'hF, 3, 5, t1);
    axi_write(16'h0003, 1, 32'h9999_AAAA, 4'hF, 0, 5, t1);
    axi_write(16'h0003, 1, 32'h1234_5678, 4'hF, -2, 0, t1);
    axi_write(16'h0004, 0, 32'h0000_0000, 4'hF, 0, 0, t1);
    axi_write(16'h0004, 0, 32'hFFFF_FFFF, 4'b0101, 0, 0, t1);
    chk("strb_stage", ref_stage, 32'h00FF00FF);
    axi_write(16'h0004, 1, 32'hCAFE_F00D, 4'b1001, 0, 0, t1);
    axi_read(16'h0002, 0, 0, 0);
    axi_read(16'h0002, 1, 2, 0);
    axi_read(16'h0004, 0, 1, 0);
    axi_read(16'h0004, 1, 0, 0);
    fork
      axi_write(16'h0005, 1, 32'h0BAD_C0DE, 4'hF, 0, 2, ta);
      axi_read(16'h0009, 0, 1, 0);
    join
    chk("same_cycle_strobes", wen_cyc, ren_cyc);
    axi_write(16'h0006, 1, 32'h1357_9BDF, 4'hF, 0, 0, t1);
    axi_write(16'h0007, 1, 32'h2468_ACE0, 4'hF, 0, 0, t2);
    chk("write_throughput", 32'(t2 - t1), 32'd2);
    axi_read(16'h000A, 0, 0, 1);
    @(negedge clk);
    do_reset();
    axi_write(16'h000B, 1, 32'hFACE_B00C, 4'hF, 0, -1, t1);
    do_reset();
    axi_read(16'h000B, 0, 0, 0);
    for (int n = 0; n < 60; n++) begin
      ri = int'($urandom_range(0, 15));
      rh = 1'($urandom_range(0, 1));
      rop = int'($urandom_range(0, 1));
      if (rop == 1) axi_write(16'(ri), rh, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)), tb_);
      else axi_read(16'(ri), rh, int'($urandom_range(0, 3)), 0);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", {exp_wen.size() == 0, exp_ren.size() == 0, exp_rd.size() == 0, exp_b == 0}, 4'hF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
